barret_2237_arbiter: RTL

//  Shares one barret_for_2237 reducer (combinational, din_a[22:0] -> dout_r[11:0]) between
//  NUM_REQ requesters. Round-robin arbitration, valid/ready on both sides, 2-stage pipeline

---
 rtl/barret_2237_pkg.sv | 24 ++
 rtl/barret_2237_rr_pick.sv | 36 +++
 rtl/barret_for_2237.sv | 29 ++
 rtl/barret_2237_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/barret_2237_pkg.sv
// Shared constants, slot state encoding and stage-1 payload for the
// barret_2237 reduction arbiter.
package barret_2237_pkg;

  localparam int unsigned Q      = 2237;
  localparam int unsigned Q_SQ   = Q * Q;
  localparam int unsigned DIN_W  = 23;
  localparam int unsigned DOUT_W = 12;
  // Source id field is sized for the largest supported requester count (8).
  localparam int unsigned SRC_W  = 3;

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_INFLIGHT = 2'd1,
    SLOT_HOLD     = 2'd2
  } slot_state_e;

  typedef struct packed {
    logic [DIN_W-1:0] operand;
    logic [SRC_W-1:0] src;
    logic             err;
  } s1_payload_t;

endpackage

// File: rtl/barret_2237_rr_pick.sv
// Round-robin picker: first eligible index strictly after ptr_i, modulo NUM_REQ.
// Ports: eligible_i (request mask), ptr_i (last granted index),
//        grant_o (one-hot), idx_o (granted index), valid_o (any grant).
module barret_2237_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int unsigned     cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = 32'(ptr_i) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid_o && eligible_i[cand_idx]) begin
        valid_o           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/barret_for_2237.sv
// Combinational Barrett reducer: dout_r = din_a mod 2237 for operands below Q*Q.
// Ports: din_a (23-bit operand), dout_r (12-bit residue).
module barret_for_2237 (
  input  logic [22:0] din_a,
  output logic [11:0] dout_r
);

  // floor(2^24 / 2237); quotient estimate undershoots by at most two.
  localparam int unsigned M_BAR = 7499;
  localparam int unsigned Q_RED = 2237;

  logic [35:0] prod;
  logic [11:0] qhat;
  logic [23:0] qq;
  logic [13:0] r0;
  logic [13:0] r1;
  logic [13:0] r2;

  always_comb begin
    prod   = 36'(din_a) * 36'(M_BAR);
    qhat   = 12'(prod >> 24);
    qq     = 24'(qhat) * 24'(Q_RED);
    r0     = 14'(24'(din_a) - qq);
    r1     = (r0 >= 14'(Q_RED)) ? (r0 - 14'(Q_RED)) : r0;
    r2     = (r1 >= 14'(Q_RED)) ? (r1 - 14'(Q_RED)) : r1;
    dout_r = 12'(r2);
  end

endmodule

// File: rtl/barret_2237_arbiter.sv
// Shares one barret_for_2237 reducer between NUM_REQ requesters with round-robin
// arbitration, a stage-1 register ahead of the reducer and one result slot per requester.
// Ports: clk, rst_n (async active-low); req_valid_i/req_data_i/req_ready_o (operand side,
//        req_ready_o is a combinational one-hot grant); resp_valid_o/resp_data_o/resp_err_o/
//        resp_ready_i (result side); busy_o (any slot active); ops_done_o (handshake count).
module barret_2237_arbiter
  import barret_2237_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DIN_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  output logic [NUM_REQ*DOUT_W-1:0] resp_data_o,
  output logic [NUM_REQ-1:0]        resp_err_o,
  input  logic [NUM_REQ-1:0]        resp_ready_i,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          ops_done_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  slot_state_e               slot_q [NUM_REQ];
  slot_state_e               slot_d [NUM_REQ];
  logic [NUM_REQ-1:0]        resp_valid_q, resp_valid_d;
  logic [NUM_REQ*DOUT_W-1:0] resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0]        resp_err_q, resp_err_d;
  logic                      s1_valid_q, s1_valid_d;
  s1_payload_t               s1_q, s1_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]          ops_done_q, ops_done_d;
  logic                      busy_q, busy_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [DIN_W-1:0]   pick_opnd;
  logic [IDX_W-1:0]   s1_src;
  logic [DOUT_W-1:0]  red_res;
  logic [CNT_W-1:0]   hs_cnt;

  // Eligibility uses registered slot state so a slot freed this edge waits a cycle.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid_i[i] && (slot_q[i] == SLOT_IDLE);
    end
  end

  barret_2237_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (pick_grant),
    .idx_o      (pick_idx),
    .valid_o    (pick_valid)
  );

  // Grant is forced low while reset is asserted so every output reads 0 during reset.
  assign req_ready_o = pick_grant & {NUM_REQ{rst_n}};
  assign pick_opnd   = req_data_i[32'(pick_idx)*DIN_W +: DIN_W];
  assign s1_src      = IDX_W'(s1_q.src);

  barret_for_2237 u_reducer (
    .din_a  (s1_q.operand),
    .dout_r (red_res)
  );

  // Next-state: response handshakes, stage-1 writeback, new accept, counters.
  always_comb begin
    slot_d       = slot_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    s1_valid_d   = 1'b0;
    s1_d         = '0;
    ptr_d        = ptr_q;
    hs_cnt       = '0;
    busy_d       = 1'b0;

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (resp_valid_q[i] && resp_ready_i[i]) begin
        slot_d[i]                       = SLOT_IDLE;
        resp_valid_d[i]                 = 1'b0;
        resp_data_d[i*DOUT_W +: DOUT_W] = '0;
        resp_err_d[i]                   = 1'b0;
        hs_cnt                          = hs_cnt + CNT_W'(1);
      end
    end

    // Out-of-range operands bypass the reducer result entirely.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (s1_valid_q && (s1_src == IDX_W'(i))) begin
        slot_d[i]                       = SLOT_HOLD;
        resp_valid_d[i]                 = 1'b1;
        resp_data_d[i*DOUT_W +: DOUT_W] = s1_q.err ? '0 : red_res;
        resp_err_d[i]                   = s1_q.err;
      end
    end

    if (pick_valid) begin
      s1_valid_d    = 1'b1;
      s1_d.operand  = pick_opnd;
      s1_d.src      = SRC_W'(pick_idx);
      s1_d.err      = (pick_opnd >= DIN_W'(Q_SQ));
      ptr_d         = pick_idx;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (pick_grant[i]) slot_d[i] = SLOT_INFLIGHT;
      end
    end

    ops_done_d = ops_done_q + hs_cnt;

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (slot_d[i] != SLOT_IDLE) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) slot_q[i] <= SLOT_IDLE;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      ptr_q        <= IDX_W'(NUM_REQ - 1);
      ops_done_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) slot_q[i] <= slot_d[i];
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      ptr_q        <= ptr_d;
      ops_done_q   <= ops_done_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign busy_o       = busy_q;
  assign ops_done_o   = ops_done_q;

endmodule
